// File: rtl/range_seq_pkg.sv
// Shared types and helpers for the range-finder window sequencer.
package range_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        WAIT,
        CAPT
    } seq_state_t;

    // Shortest legal window; keeps rf_go and rf_finish on separate cycles.
    localparam int MIN_LEN = 2;

    function automatic int clamp_len(input int len, input int max_len);
        if (len < MIN_LEN) begin
            return MIN_LEN;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/range_window_sequencer.sv
// Frames a valid/ready sample stream into go/finish windows for the range-finder
// core and holds each window's result in a one-entry valid/ready register.
module range_window_sequencer
    import range_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LW-1:0]    cfg_len,
    input  logic             cfg_cont,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic [WIDTH-1:0] rf_data,
    output logic             rf_go,
    output logic             rf_finish,
    output logic             rf_rst,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_error,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_range,
    output logic             res_error,
    output logic             busy,
    output logic             overrun
);

    seq_state_t    state;
    logic [LW-1:0] cnt;
    logic [LW-1:0] cnt_inc;
    logic [LW-1:0] len_q;
    logic          cont_q;
    logic          accept;

    assign accept  = s_valid && s_ready;
    // cnt stays below len_q inside a window, so the increment cannot wrap.
    assign cnt_inc = cnt + LW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= LW'(MIN_LEN);
            cont_q    <= 1'b0;
            s_ready   <= 1'b0;
            rf_data   <= '0;
            rf_go     <= 1'b0;
            rf_finish <= 1'b0;
            rf_rst    <= 1'b1;
            res_valid <= 1'b0;
            res_range <= '0;
            res_error <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rf_go     <= 1'b0;
            rf_finish <= 1'b0;
            rf_rst    <= 1'b0;

            // A capture later in this block overrides the consume.
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            if (abort && state != IDLE) begin
                state   <= IDLE;
                cnt     <= '0;
                rf_rst  <= 1'b1;
                s_ready <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            len_q   <= LW'(clamp_len(int'(cfg_len), MAX_LEN));
                            cont_q  <= cfg_cont;
                            cnt     <= '0;
                            state   <= ARMED;
                            s_ready <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (accept) begin
                            rf_data <= s_data;
                            rf_go   <= 1'b1;
                            cnt     <= LW'(1);
                            state   <= RUN;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            rf_data <= s_data;
                            cnt     <= cnt_inc;
                            if (cnt_inc == len_q) begin
                                rf_finish <= 1'b1;
                                state     <= WAIT;
                                s_ready   <= 1'b0;
                            end
                        end
                    end
                    WAIT: begin
                        state <= CAPT;
                    end
                    CAPT: begin
                        res_range <= rf_range;
                        res_error <= rf_error;
                        res_valid <= 1'b1;
                        if (res_valid && !res_ready) begin
                            overrun <= 1'b1;
                        end
                        if (cont_q) begin
                            state   <= ARMED;
                            s_ready <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_range_window_sequencer.sv
// Self-checking bench: behavioural range-finder core plus a result scoreboard.
module tb_range_window_sequencer;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             start     = 1'b0;
    logic             abort     = 1'b0;
    logic [LW-1:0]    cfg_len   = '0;
    logic             cfg_cont  = 1'b0;
    logic             s_valid   = 1'b0;
    logic [WIDTH-1:0] s_data    = '0;
    logic             res_ready = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] rf_data;
    logic             rf_go;
    logic             rf_finish;
    logic             rf_rst;
    logic [WIDTH-1:0] rf_range  = '0;
    logic             rf_error  = 1'b0;
    logic             res_valid;
    logic [WIDTH-1:0] res_range;
    logic             res_error;
    logic             busy;
    logic             overrun;

    int total = 0;
    int bad   = 0;
    logic [WIDTH:0] exp_q[$];
    logic err_inject = 1'b0;

    range_window_sequencer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_len(cfg_len), .cfg_cont(cfg_cont),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .rf_data(rf_data), .rf_go(rf_go), .rf_finish(rf_finish), .rf_rst(rf_rst),
        .rf_range(rf_range), .rf_error(rf_error),
        .res_valid(res_valid), .res_ready(res_ready), .res_range(res_range),
        .res_error(res_error), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Behavioural core: tracks min/max from rf_go through rf_finish.
    logic             c_act = 1'b0;
    logic [WIDTH-1:0] c_min = '0;
    logic [WIDTH-1:0] c_max = '0;
    logic [WIDTH-1:0] n_min;
    logic [WIDTH-1:0] n_max;
    assign n_min = (rf_data < c_min) ? rf_data : c_min;
    assign n_max = (rf_data > c_max) ? rf_data : c_max;

    always @(posedge clk) begin
        if (rf_rst === 1'b1) begin
            c_act    <= 1'b0;
            c_min    <= '0;
            c_max    <= '0;
            rf_range <= '0;
            rf_error <= 1'b0;
        end else if (rf_go === 1'b1) begin
            c_act <= 1'b1;
            c_min <= rf_data;
            c_max <= rf_data;
        end else if (c_act) begin
            c_min <= n_min;
            c_max <= n_max;
            if (rf_finish === 1'b1) begin
                rf_range <= n_max - n_min;
                rf_error <= err_inject;
                c_act    <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // A handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("result", 32'({res_error, res_range}), 32'(exp_q.pop_front()));
                $display("result range=%0d error=%0b", res_range, res_error);
            end
        end
    end

    task automatic drive_sample(input logic [WIDTH-1:0] d);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic do_start(input logic [LW-1:0] len, input logic cont);
        start    = 1'b1;
        cfg_len  = len;
        cfg_cont = cont;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(s_ready), 32'd1);
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_rf_rst", 32'(rf_rst), 32'd1);
        chk("abort_idle", 32'({busy, s_ready, rf_go, rf_finish}), 32'd0);
    endtask

    task automatic send_window(input logic [WIDTH-1:0] a, b, c, d, input int n,
                               input int gap, input bit poke, input bit err);
        logic [WIDTH-1:0] v[4];
        logic [WIDTH-1:0] mn;
        logic [WIDTH-1:0] mx;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        mn = a;
        mx = a;
        for (int i = 1; i < n; i++) begin
            if (v[i] < mn) mn = v[i];
            if (v[i] > mx) mx = v[i];
        end
        err_inject = err;
        for (int i = 0; i < n; i++) begin
            drive_sample(v[i]);
            chk("rf_data", 32'(rf_data), 32'(v[i]));
            chk("rf_go", 32'(rf_go), 32'(i == 0));
            chk("rf_finish", 32'(rf_finish), 32'(i == n - 1));
            if (i == n - 1) begin
                exp_q.push_back({err, WIDTH'(mx - mn)});
            end else begin
                for (int g = 0; g < gap; g++) begin
                    if (poke && g == 0) begin
                        start   = 1'b1;
                        cfg_len = LW'(2);
                    end
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    chk("gap_hold", 32'(rf_data), 32'(v[i]));
                    chk("gap_pulses", 32'({rf_go, rf_finish}), 32'd0);
                end
            end
        end
    endtask

    initial begin
        int n;

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_outputs", 32'({s_ready, rf_data, rf_go, rf_finish, res_valid,
                                  res_range, res_error, overrun, busy}), 32'd0);
        chk("reset_rf_rst", 32'(rf_rst), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rf_rst_release", 32'(rf_rst), 32'd0);

        // Back-to-back window with latency check.
        res_ready = 1'b1;
        do_start(LW'(4), 1'b0);
        send_window(8'd10, 8'd3, 8'd7, 8'd20, 4, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("latency_e1", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        chk("latency_e2", 32'(res_valid), 32'd1);
        chk("idle_after_single", 32'(busy), 32'd0);
        repeat (2) begin @(posedge clk); #1; end

        // Gapped window, mid-window start ignored, core error propagated.
        do_start(LW'(4), 1'b0);
        send_window(8'd50, 8'd60, 8'd55, 8'd40, 4, 3, 1'b1, 1'b1);
        repeat (4) begin @(posedge clk); #1; end

        // Continuous mode, s_ready low for exactly two cycles between windows.
        do_start(LW'(2), 1'b1);
        send_window(8'd5, 8'd9, 8'd0, 8'd0, 2, 0, 1'b0, 1'b0);
        n = 0;
        while (!s_ready && n < 10) begin
            n++;
            @(posedge clk); #1;
        end
        chk("cont_ready_gap", 32'(n), 32'd2);
        send_window(8'd100, 8'd1, 8'd0, 8'd0, 2, 0, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        pulse_abort();

        // Overrun: second result overwrites an unconsumed first one.
        res_ready = 1'b0;
        do_start(LW'(2), 1'b1);
        send_window(8'd3, 8'd8, 8'd0, 8'd0, 2, 0, 1'b0, 1'b0);
        send_window(8'd20, 8'd30, 8'd0, 8'd0, 2, 0, 1'b0, 1'b0);
        chk("overrun_before", 32'(overrun), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("overrun_valid", 32'(res_valid), 32'd1);
        void'(exp_q.pop_front());
        pulse_abort();
        res_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Length clamps: 1 behaves as 2, 31 behaves as MAX_LEN.
        do_start(LW'(1), 1'b0);
        send_window(8'd40, 8'd45, 8'd0, 8'd0, 2, 0, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        do_start(LW'(31), 1'b0);
        for (int i = 0; i < MAX_LEN; i++) begin
            drive_sample(WIDTH'(i * 3));
            chk("long_finish", 32'(rf_finish), 32'(i == MAX_LEN - 1));
        end
        exp_q.push_back({1'b0, WIDTH'((MAX_LEN - 1) * 3)});
        repeat (4) begin @(posedge clk); #1; end

        // Abort mid-window, then a clean window.
        do_start(LW'(4), 1'b0);
        drive_sample(8'd11);
        drive_sample(8'd99);
        pulse_abort();
        chk("abort_keeps_overrun", 32'(overrun), 32'd1);
        @(posedge clk); #1;
        chk("abort_rf_rst_end", 32'(rf_rst), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_no_result", 32'(res_valid), 32'd0);
        do_start(LW'(4), 1'b0);
        send_window(8'd8, 8'd2, 8'd6, 8'd4, 4, 0, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end

        // Reset taken mid-window.
        do_start(LW'(4), 1'b0);
        drive_sample(8'd1);
        drive_sample(8'd200);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_outputs", 32'({s_ready, rf_data, rf_go, rf_finish, res_valid,
                                   res_range, res_error, overrun, busy}), 32'd0);
        chk("midrst_rf_rst", 32'(rf_rst), 32'd1);
        @(posedge clk); #1;
        chk("midrst_rf_rst_end", 32'(rf_rst), 32'd0);

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
